// File: rtl/window_gen_3x3.sv
// ============================================================================
// Module   : window_gen_3x3
// Purpose  : Raster pixel stream to 3x3 neighbourhood window, two line buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module window_gen_3x3 #(
    parameter int N     = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic          in_valid,
    input  logic [N-1:0]  in_pix,
    output logic [N-1:0]  w1,
    output logic [N-1:0]  w2,
    output logic [N-1:0]  w3,
    output logic [N-1:0]  w4,
    output logic [N-1:0]  w5,
    output logic [N-1:0]  w6,
    output logic [N-1:0]  w7,
    output logic [N-1:0]  w8,
    output logic [N-1:0]  w9,
    output logic          out_valid,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          frame_done
);

    localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [N-1:0]  r_lb1 [IMG_W];
    logic [N-1:0]  r_lb2 [IMG_W];
    logic [N-1:0]  r_win [9];

    // sof coincident with a pixel makes that pixel position (0,0)
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_emit;
    logic [N-1:0]  w_p1;
    logic [N-1:0]  w_p2;

    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_last_col = (w_col == C_LAST_COL);
    assign w_last_row = (w_row == C_LAST_ROW);
    assign w_emit     = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_p1       = r_lb1[IMG_W-1];
    assign w_p2       = r_lb2[IMG_W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end else if (sof) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= w_emit;
            frame_done <= in_valid && w_last_col && w_last_row;
            if (w_emit) begin
                out_row <= w_row - 1'b1;
                out_col <= w_col - 1'b1;
            end
        end
    end

    // Each line is IMG_W deep, so its tail is the pixel one row above
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
        end else if (in_valid) begin
            r_lb1[0] <= in_pix;
            r_lb2[0] <= w_p1;
            for (int i = 1; i < IMG_W; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (in_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_p2;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_p1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= in_pix;
        end
    end

    assign w1 = r_win[0];
    assign w2 = r_win[1];
    assign w3 = r_win[2];
    assign w4 = r_win[3];
    assign w5 = r_win[4];
    assign w6 = r_win[5];
    assign w7 = r_win[6];
    assign w8 = r_win[7];
    assign w9 = r_win[8];

endmodule

`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
// ============================================================================
// Module   : tb_window_gen_3x3
// Purpose  : Directed and random frames for window_gen_3x3 against an image model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_window_gen_3x3;

    localparam int N = 8;
    localparam int W = 4;
    localparam int H = 4;

    localparam logic [71:0] C_WIN_FIRST = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    localparam logic [71:0] C_WIN_LAST  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    localparam logic [71:0] C_WIN_F2    = {8'd16, 8'd17, 8'd18, 8'd20, 8'd21, 8'd22, 8'd24, 8'd25, 8'd26};

    logic         clk = 1'b0;
    logic         rst;
    logic         sof;
    logic         in_valid;
    logic [N-1:0] in_pix;
    logic [N-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic         out_valid;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         frame_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(.N(N), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_pix(in_pix),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    wire [71:0] taps = {w1, w2, w3, w4, w5, w6, w7, w8, w9};

    int checks   = 0;
    int failures = 0;

    // Image model: position of next pixel and the pixels of the current frame
    int          mr = 0;
    int          mc = 0;
    logic [7:0]  img [H][W];
    logic [71:0] exp_taps = '0;
    int          erow = 0;
    int          ecol = 0;
    bit          win_known = 0;

    int          seen = 0;
    int          acc_in_frame = 0;
    int          first_at = 0;
    int          first_avg = 0;
    int          first_r = 0;
    int          first_c = 0;
    int          last_r = 0;
    int          last_c = 0;
    int          fd_count = 0;
    int          fd0 = 0;
    logic [71:0] first_obs = '0;
    logic [71:0] last_obs = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        bit          ev  = 0;
        bit          efd = 0;
        logic [71:0] ew  = '0;
        in_valid = v;
        sof      = s;
        in_pix   = p;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        if (v) begin
            if (mr == 0 && mc == 0) begin
                seen = 0;
                acc_in_frame = 0;
            end
            acc_in_frame++;
            img[mr][mc] = p;
            ev  = (mr >= 2) && (mc >= 2);
            efd = (mr == H-1) && (mc == W-1);
            if (ev) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[8*(8-(3*i+j)) +: 8] = img[mr-2+i][mc-2+j];
                exp_taps = ew;
                erow = mr - 1;
                ecol = mc - 1;
            end
            win_known = ev;
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {71'd0, out_valid}, {71'd0, ev});
        chk("frame_done", {71'd0, frame_done}, {71'd0, efd});
        if (win_known) begin
            chk("taps", taps, exp_taps);
            chk("out_row", 72'(out_row), 72'(erow));
            chk("out_col", 72'(out_col), 72'(ecol));
        end
        if (out_valid) begin
            seen++;
            if (seen == 1) begin
                first_obs = taps;
                first_at  = acc_in_frame;
                first_r   = int'(out_row);
                first_c   = int'(out_col);
                first_avg = (int'(w1) + int'(w2) + int'(w3) + int'(w4) + int'(w5)
                           + int'(w6) + int'(w7) + int'(w8) + int'(w9)) >> 4;
            end
            last_obs = taps;
            last_r   = int'(out_row);
            last_c   = int'(out_col);
        end
        if (frame_done) fd_count++;
        if (efd) chk("win_count", 72'(seen), 72'((W-2)*(H-2)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_taps"}, taps, '0);
        chk({tag, "_valid"}, {71'd0, out_valid}, '0);
        chk({tag, "_row"}, 72'(out_row), '0);
        chk({tag, "_col"}, 72'(out_col), '0);
        chk({tag, "_fd"}, {71'd0, frame_done}, '0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_zero(tag);
        @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b1;
        mr = 0;
        mc = 0;
        win_known = 0;
        seen = 0;
    endtask

    task automatic send_frame(input int base, input bit with_sof, input bit toggle);
        for (int k = 0; k < W*H; k++) begin
            step(1'b1, with_sof && (k == 0), 8'(base + k));
            if (toggle) step(1'b0, 1'b0, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        sof = 1'b0;
        in_valid = 1'b0;
        in_pix = '0;
        #12;
        check_zero("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Continuous frame, then the next frame with no sof and no gap
        fd0 = fd_count;
        send_frame(0, 1'b1, 1'b0);
        chk("s1_first", first_obs, C_WIN_FIRST);
        chk("s1_first_at", 72'(first_at), 72'd11);
        chk("s1_first_pos", 72'({first_r, first_c}), 72'({32'd1, 32'd1}));
        chk("s1_avg", 72'(first_avg), 72'd2);
        chk("s1_last", last_obs, C_WIN_LAST);
        chk("s1_last_pos", 72'({last_r, last_c}), 72'({32'd2, 32'd2}));
        chk("s1_fd", 72'(fd_count - fd0), 72'd1);
        send_frame(16, 1'b0, 1'b0);
        chk("s2_first", first_obs, C_WIN_F2);
        chk("s2_first_pos", 72'({first_r, first_c}), 72'({32'd1, 32'd1}));
        chk("s2_fd", 72'(fd_count - fd0), 72'd2);
        step(1'b0, 1'b0, 8'd0);

        // Toggled in_valid
        send_frame(0, 1'b1, 1'b1);
        chk("tog_first", first_obs, C_WIN_FIRST);
        chk("tog_last", last_obs, C_WIN_LAST);

        // Aborted partial frame restarted by sof with a pixel
        for (int k = 0; k < 6; k++) step(1'b1, k == 0, 8'(100 + k));
        send_frame(0, 1'b1, 1'b0);
        chk("abort_first", first_obs, C_WIN_FIRST);
        chk("abort_last", last_obs, C_WIN_LAST);

        // sof alone clears position
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 8'(200 + k));
        step(1'b0, 1'b1, 8'd0);
        send_frame(0, 1'b0, 1'b0);
        chk("sofonly_first", first_obs, C_WIN_FIRST);

        // Reset mid-frame
        for (int k = 0; k < 10; k++) step(1'b1, k == 0, 8'(k));
        do_reset("rst_mid");
        send_frame(0, 1'b0, 1'b0);
        chk("rst_first_at", 72'(first_at), 72'd11);
        chk("rst_first", first_obs, C_WIN_FIRST);

        // Random pixels, gaps and occasional stray sof
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < W*H; k++) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'b0, ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
                step(1'b1, (k == 0) && (f % 2 == 0), 8'($urandom_range(0, 255)));
            end
        end
        step(1'b0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Raster-order pixel stream in; 3x3 neighbourhood window out, with nine taps w1..w9.
- Sits upstream of the team's 9-operand adder/averager and drives its op1..op9 inputs directly, w1->op1 ... w9->op9.
- Two internal line buffers hold the previous image rows.
- One window is emitted per accepted pixel once a full 3x3 neighbourhood exists.

Parameters:
- N, 8: pixel width in bits.
- IMG_W, 8: pixels per line; must be >= 3.
- IMG_H, 8: lines per frame; must be >= 3.
- Local: CW = $clog2(IMG_W), RW = $clog2(IMG_H).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sof  in  1  start of frame; restarts position counters.
- in_valid  in  1  in_pix is accepted this cycle. No backpressure: every in_valid=1 cycle is accepted.
- in_pix  in  N  pixel, raster order (left to right, then top to bottom).
- w1..w9  out  N each  window taps, row-major. w1 = top-left (row r-2, col c-2); w9 = bottom-right (row r, col c, the newest pixel).
- out_valid  out  1  w1..w9, out_row and out_col hold a new valid window this cycle.
- out_row  out  RW  window centre row, r-1.
- out_col  out  CW  window centre column, c-1.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset (rst=0, async): all outputs 0; col/row counters 0; line buffers and window registers 0. Reset mid-frame abandons that frame; the next accepted pixel is row 0, col 0.
- Position: (r,c) is the pre-increment value of the row/col counters for the accepted pixel.
  - sof=1 together with in_valid=1: that pixel is (0,0).
  - sof=1 alone: counters cleared to 0; nothing else changes; out_valid=0.
- Counters on accept:
  - c increments.
  - c=IMG_W-1 wraps c to 0 and increments r.
  - (r,c) = (IMG_H-1, IMG_W-1) wraps both to 0 and sets frame_done=1 on the next cycle.
- Line buffers: lb1 and lb2 are IMG_W-deep shift lines, shifted only on accept.
  - lb1 input = in_pix; lb2 input = lb1 output.
  - Taps: p0 = in_pix, p1 = lb1 out (pixel above), p2 = lb2 out (two above).
- Window: 3x3 register array, shifted left one column on accept. New right column = {p2, p1, p0}, giving w3/w6/w9 respectively.
- Latency and validity:
  - 1 cycle from the accepting edge to registered outputs.
  - out_valid=1 in the cycle after accepting a pixel with r>=2 and c>=2; otherwise 0.
- Idle: in_valid=0 holds all state; w*/out_row/out_col keep their last values; out_valid=0.
- Row boundary: window columns straddle lines after a wrap, but these windows are masked by the c>=2 condition and never emitted.
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- Line buffers are not cleared on sof; rows 0..1 of each frame refill them before any window is emitted.
- Back-to-back frames are supported with no gap cycles.
- Widths: pixels pass through unmodified, with no arithmetic on data.

Test Plan (N=8, IMG_W=4, IMG_H=4, pixel value = 4r+c):
- Frame 0..15, in_valid continuous, sof on pixel 0:
  - Exactly 4 out_valid pulses, after pixels 10, 11, 14, 15.
  - First window w1..w9 = 0,1,2,4,5,6,8,9,10 with out_row=1, out_col=1.
  - Last window = 5,6,7,9,10,11,13,14,15 with centre (2,2).
  - frame_done pulses once, the cycle after pixel 15.
- Same frame with in_valid toggling 1,0,1,0...: identical window sequence; out_valid never set on an idle cycle; taps hold between windows.
- Second frame 16..31 immediately following, no sof: first window = 16,17,18,20,21,22,24,25,26, centre (1,1); 4 windows; second frame_done.
- sof pulse together with the pixel after 6 pixels were sent, then a full 0..15 frame: windows identical to scenario 1; no window emitted from the aborted partial frame.
- rst=0 asserted after pixel 9, released, then a full frame: all outputs 0 during reset; first out_valid occurs after the 11th post-reset pixel with taps 0,1,2,4,5,6,8,9,10.
- Taps w1..w9 connected to the adder9x averager: after pixel 10 the averager result = 45>>4 = 2.
